// File: rtl/fifo_wr_arbiter_if.sv
// Producer streams plus the FIFO write-side signals that fifo_wr_arbiter multiplexes.
// The slave modport is the arbiter's view; master is the view of the surrounding logic.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int WORD_WIDTH = 8,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]            req_vld_in;
   logic [NUM_REQ*WORD_WIDTH-1:0] req_data_in;
   logic [NUM_REQ-1:0]            req_rdy_out;
   logic                          fifo_full_in;
   logic                          fifo_write_en_out;
   logic [WORD_WIDTH-1:0]         fifo_data_out;
   logic [NUM_REQ-1:0]            grant_out;
   logic [ID_WIDTH-1:0]           grant_id_out;
   logic                          busy_out;

   modport slave (
      input  req_vld_in, req_data_in, fifo_full_in,
      output req_rdy_out, fifo_write_en_out, fifo_data_out,
             grant_out, grant_id_out, busy_out
   );

   modport master (
      output req_vld_in, req_data_in, fifo_full_in,
      input  req_rdy_out, fifo_write_en_out, fifo_data_out,
             grant_out, grant_id_out, busy_out
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready producers,
// granting one producer at a time for bursts of up to MAX_BURST beats.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int WORD_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic              clk_in,
   input  logic              reset_n_in,
   fifo_wr_arbiter_if.slave  bus
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t              state;
   logic [ID_WIDTH-1:0] owner;
   logic [ID_WIDTH-1:0] last;
   logic [CNT_W-1:0]    beat_cnt;
   logic [NUM_REQ-1:0]  grant_q;
   logic [ID_WIDTH-1:0] grant_id_q;
   logic                busy_q;

   logic [ID_WIDTH-1:0] pick;
   logic                in_grant;
   logic                owner_vld;
   logic                xfer;
   logic                last_beat;
   logic [NUM_REQ-1:0]  rdy;

   // First set valid bit searching cyclically upward from from+1; the lowest offset wins.
   function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                   input logic [ID_WIDTH-1:0] from);
      logic [ID_WIDTH-1:0] sel;
      logic [ID_WIDTH-1:0] cand;
      int                  idx;
      sel = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx  = (int'(from) + i) % NUM_REQ;
         cand = ID_WIDTH'(idx);
         if (vld[cand]) sel = cand;
      end
      return sel;
   endfunction

   assign pick      = rr_pick(bus.req_vld_in, last);
   assign in_grant  = (state == GRANT);
   assign owner_vld = bus.req_vld_in[owner];
   assign xfer      = in_grant & owner_vld & ~bus.fifo_full_in;
   assign last_beat = (beat_cnt == CNT_W'(MAX_BURST - 1));

   always_comb begin
      rdy = '0;
      if (in_grant) rdy[owner] = ~bus.fifo_full_in;
   end

   assign bus.req_rdy_out       = rdy;
   assign bus.fifo_write_en_out = xfer;
   assign bus.fifo_data_out     = in_grant ? bus.req_data_in[int'(owner)*WORD_WIDTH +: WORD_WIDTH]
                                           : '0;
   assign bus.grant_out         = grant_q;
   assign bus.grant_id_out      = grant_id_q;
   assign bus.busy_out          = busy_q;

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state      <= IDLE;
         owner      <= '0;
         last       <= ID_WIDTH'(NUM_REQ - 1);
         beat_cnt   <= '0;
         grant_q    <= '0;
         grant_id_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|bus.req_vld_in) begin
                  state      <= GRANT;
                  owner      <= pick;
                  beat_cnt   <= '0;
                  grant_q    <= NUM_REQ'(1) << pick;
                  grant_id_q <= pick;
                  busy_q     <= 1'b1;
               end
            end
            GRANT: begin
               // A dropped valid releases even under full; a full FIFO otherwise freezes the burst.
               if (!owner_vld || (xfer && last_beat)) begin
                  state      <= IDLE;
                  last       <= owner;
                  beat_cnt   <= '0;
                  grant_q    <= '0;
                  grant_id_q <= '0;
                  busy_q     <= 1'b0;
               end else if (xfer) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `fifo` write port between `NUM_REQ` producers. Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst. It forwards the granted producer's beats to the FIFO's `write_en_in`/`data_in`, and it stalls on the FIFO's `fifo_full_out`. The block sits directly in front of the FIFO write side; the FIFO read side is untouched.

## Interface
Parameters:
- `NUM_REQ`, 4: number of producers; must be at least 2.
- `WORD_WIDTH`, 8: data width; must match the FIFO's `WORD_WIDTH`.
- `MAX_BURST`, 4: maximum beats per grant; must be at least 1.
- `ID_WIDTH`, $clog2(NUM_REQ): width of the grant index.

Ports:
- `clk_in`  in  1  Single clock; all state changes on the rising edge.
- `reset_n_in`  in  1  Reset, asynchronous and active-low.
- `req_vld_in`  in  NUM_REQ  Per-producer valid.
- `req_data_in`  in  NUM_REQ*WORD_WIDTH  Producer i's data occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
- `req_rdy_out`  out  NUM_REQ  Per-producer ready; one-hot or zero.
- `fifo_full_in`  in  1  Connects to the FIFO's `fifo_full_out`.
- `fifo_write_en_out`  out  1  Connects to the FIFO's `write_en_in`.
- `fifo_data_out`  out  WORD_WIDTH  Connects to the FIFO's `data_in`.
- `grant_out`  out  NUM_REQ  One-hot current owner; zero when IDLE.
- `grant_id_out`  out  ID_WIDTH  Index of the current owner; 0 when IDLE.
- `busy_out`  out  1  High in state GRANT.

## Operation
The arbiter is a two-state FSM (IDLE, GRANT). Its registers are:
- `state`
- `owner` (ID_WIDTH bits)
- `last` (ID_WIDTH bits), the most recent owner
- `beat_cnt`, $clog2(MAX_BURST+1) bits

**IDLE:**
- No grant is active, and all ready and write outputs are 0.
- If any `req_vld_in` bit is 1, select the first set bit searching cyclically from `last+1` (mod NUM_REQ).
- Load `owner` with that index, clear `beat_cnt`, and go to GRANT.
- If no valid is set, stay in IDLE.

**GRANT:**
- `req_rdy_out[owner] = !fifo_full_in`.
- `fifo_write_en_out = req_vld_in[owner] & !fifo_full_in`.
- `fifo_data_out` is the owner's data slice, driven whenever the state is GRANT.
- A transfer is a cycle with `fifo_write_en_out = 1`. Each transfer increments `beat_cnt`.

**Release.** The arbiter leaves GRANT for IDLE at the clock edge, and loads `last <= owner`, when either condition holds:
- (a) `req_vld_in[owner] = 0`, or
- (b) a transfer occurs with `beat_cnt == MAX_BURST-1`.

**Rules:**
- `fifo_full_in = 1` in GRANT stalls the burst. The arbiter holds `owner` and `beat_cnt`, and the grant is not released.
- Release condition (a) takes effect even while the FIFO is full.
- Non-owner producers always see ready = 0. Their valid and data are ignored until they are granted.
- Producers must hold valid and data stable until accepted. The arbiter does not check this.
- The round-robin wraps from NUM_REQ-1 to 0. A sole active producer is regranted after one IDLE cycle.
- The FIFO's full flag is combinational from its pointers, so a write suppressed by full is never lost.

## Timing
**Reset:** asserting `reset_n_in` low immediately forces:
- state = IDLE
- `last` = NUM_REQ-1, so producer 0 wins first
- `owner` = 0
- `beat_cnt` = 0
- all outputs 0

**Latency:**
- Grant: a valid seen in IDLE produces a grant at the next edge. The first transfer can occur in the first GRANT cycle.
- Data path: combinational, owner mux to `fifo_data_out`, with zero cycles of latency.

**Bubbles:**
- Every release costs exactly one IDLE cycle.
- Sustained throughput with all producers active and no full: MAX_BURST beats per MAX_BURST+1 cycles.

**Reset mid-burst:**
- Beats already written stay in the FIFO.
- The partially granted producer must retry.
- The FIFO's own reset is separate from this block's reset.

## Test plan
- **Reset and first pick:** hold `reset_n_in` low with `req_vld_in=4'b0101`; expect all outputs 0. Release reset; at the next edge expect `grant_out=4'b0001` and `grant_id_out=0`.
- **Round-robin fairness:** all four producers valid continuously, `fifo_full_in=0`, MAX_BURST=4. Expect grant order 0,1,2,3,0, four writes per grant, and one idle cycle between grants: 16 writes in 20 cycles.
- **Full stall:** assert `fifo_full_in` for 3 cycles after beat 2 of producer 1's burst. Expect `fifo_write_en_out=0`, `req_rdy_out=0`, and the grant held. The burst resumes and totals exactly 4 beats.
- **Early release:** producer 2 drops valid after 2 beats while producer 3 is valid. Expect IDLE for one cycle, then producer 3 granted.
- **Async reset mid-burst:** pulse `reset_n_in` low mid-cycle during producer 3's burst. Expect outputs to go to 0 before the next edge, and the next grant to go to producer 0.
- **End-to-end with fifo:** connect to the FIFO with ADD_WIDTH=4. Four producers each send 8 tagged words {id,seq}. Read back 32 words; each producer's words must appear in seq order, and none may be lost or duplicated.
